// File: rtl/mips_pkg.sv
// Shared MIPS types and constants for decode, execute and writeback.
// Also holds the writeback-bypass hit test used by the register-read path.
package mips_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd31;
    localparam int       NUM_REGS = 32;

    // True when this cycle's writeback targets the given source register.
    // Register 0 is never forwarded because it is hardwired to zero.
    function automatic logic wb_hits(input logic wb_en, input reg_idx_t wb_rd,
                                     input reg_idx_t src);
        return wb_en && (wb_rd == src) && (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode-stage register-read / issue / writeback bundle.
// The master modport is the decode+writeback side; slave is the register file.
// Optional debug read port is present only when REGFILE_DBG_PORT_EN is defined.
interface regfile_scoreboard_if
`ifdef REGFILE_DBG_PORT_EN
    #(parameter int PEND_W = 2)
`endif
    ;
    import mips_pkg::*;

    reg_idx_t r1;
    reg_idx_t r2;
    logic     use1;
    logic     use2;
    word_t    v1;
    word_t    v2;
    logic     issue_en;
    reg_idx_t issue_rd;
    logic     wb_en;
    reg_idx_t wb_rd;
    word_t    wb_data;
    logic     stall;
    logic     sb_err;

`ifdef REGFILE_DBG_PORT_EN
    reg_idx_t          dbg_addr;
    word_t             dbg_data;
    logic [PEND_W-1:0] dbg_pending;

    modport master (
        output r1, r2, use1, use2, issue_en, issue_rd, wb_en, wb_rd, wb_data, dbg_addr,
        input  v1, v2, stall, sb_err, dbg_data, dbg_pending
    );

    modport slave (
        input  r1, r2, use1, use2, issue_en, issue_rd, wb_en, wb_rd, wb_data, dbg_addr,
        output v1, v2, stall, sb_err, dbg_data, dbg_pending
    );
`else
    modport master (
        output r1, r2, use1, use2, issue_en, issue_rd, wb_en, wb_rd, wb_data,
        input  v1, v2, stall, sb_err
    );

    modport slave (
        input  r1, r2, use1, use2, issue_en, issue_rd, wb_en, wb_rd, wb_data,
        output v1, v2, stall, sb_err
    );
`endif

endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Saturating pending-writer counter for one architectural register.
// ovf/unf are single-cycle pulses flagging an increment at max or a
// decrement at zero; the counter holds its value in those cases.
module sb_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              ovf,
    output logic              unf
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    // Error pulses: a coincident inc and dec cancel and can never fault.
    always_comb begin
        ovf = inc && !dec && (cnt == CNT_MAX);
        unf = dec && !inc && (cnt == '0);
    end

    // Count issues up and retirements down, saturating at both ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && !dec && !ovf) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && !unf) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 MIPS register file with a per-register pending-writer scoreboard.
// Reads are combinational with writeback bypass; stall is raised when a
// consumed source has an in-flight writer the bypass cannot cover.
// Optional feature macro: REGFILE_DBG_PORT_EN (raw debug read port).
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int PEND_W   = 2
) (
    input logic                  clk,
    input logic                  reset,
    regfile_scoreboard_if.slave  bus
);

    word_t             rf  [NUM_REGS];
    logic [PEND_W-1:0] cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] ovf_vec;
    logic [NUM_REGS-1:0] unf_vec;
    logic hit1;
    logic hit2;
    logic busy1;
    logic busy2;
    logic stall_int;
    logic iss;
    logic sb_err_q;

    // Register 0 has no counter: it is never pending and never faults.
    assign cnt[0]     = '0;
    assign inc_vec[0] = 1'b0;
    assign dec_vec[0] = 1'b0;
    assign ovf_vec[0] = 1'b0;
    assign unf_vec[0] = 1'b0;

    // Read ports, bypass-aware busy and the issue gate. Busy uses the
    // pre-update count, so a self-dependent issue only waits on older writers.
    always_comb begin
        hit1      = wb_hits(bus.wb_en, bus.wb_rd, bus.r1);
        hit2      = wb_hits(bus.wb_en, bus.wb_rd, bus.r2);
        bus.v1    = hit1 ? bus.wb_data : rf[bus.r1];
        bus.v2    = hit2 ? bus.wb_data : rf[bus.r2];
        busy1     = (cnt[bus.r1] != '0) && !((cnt[bus.r1] == PEND_W'(1)) && hit1);
        busy2     = (cnt[bus.r2] != '0) && !((cnt[bus.r2] == PEND_W'(1)) && hit2);
        stall_int = (bus.use1 && busy1) || (bus.use2 && busy2);
        iss       = bus.issue_en && !stall_int && (bus.issue_rd != REG_ZERO);
    end

    assign bus.stall  = stall_int;
    assign bus.sb_err = sb_err_q;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_sb
            assign inc_vec[gi] = iss && (bus.issue_rd == reg_idx_t'(gi));
            assign dec_vec[gi] = bus.wb_en && (bus.wb_rd == reg_idx_t'(gi));

            sb_counter #(
                .PEND_W (PEND_W)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (inc_vec[gi]),
                .dec   (dec_vec[gi]),
                .cnt   (cnt[gi]),
                .ovf   (ovf_vec[gi]),
                .unf   (unf_vec[gi])
            );
        end
    endgenerate

    // Architectural state: writeback data lands even on an underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (bus.wb_en && (bus.wb_rd != REG_ZERO)) begin
            rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Sticky scoreboard error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err_q <= 1'b0;
        end else if ((|ovf_vec) || (|unf_vec)) begin
            sb_err_q <= 1'b1;
        end
    end

`ifdef REGFILE_DBG_PORT_EN
    // Raw debug read: no bypass, no effect on stall; rf[0] is always zero.
    always_comb begin
        bus.dbg_data    = (bus.dbg_addr == REG_ZERO) ? '0 : rf[bus.dbg_addr];
        bus.dbg_pending = cnt[bus.dbg_addr];
    end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard: expected values are
// queued as stimulus is applied and popped when outputs are sampled.
module tb_regfile_scoreboard;
    import mips_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t exp_q[$];

`ifdef REGFILE_DBG_PORT_EN
    regfile_scoreboard_if #(.PEND_W(2)) bus();
`else
    regfile_scoreboard_if bus();
`endif

    regfile_scoreboard #(
        .NUM_REGS (32),
        .PEND_W   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input string tag, input logic [31:0] exp);
        exp_q.push_back('{tag, exp});
    endtask

    task automatic check_output(input logic [31:0] obs);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        bus.r1       = '0;
        bus.r2       = '0;
        bus.use1     = 1'b0;
        bus.use2     = 1'b0;
        bus.issue_en = 1'b0;
        bus.issue_rd = '0;
        bus.wb_en    = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
`ifdef REGFILE_DBG_PORT_EN
        bus.dbg_addr = '0;
`endif
        tick;
        tick;
        reset = 1'b0;

        // Reset state reads
        bus.r1 = 5'd5;
        bus.r2 = REG_RA;
        push_expect("rst_v1", 32'h0);
        push_expect("rst_v2", 32'h0);
        push_expect("rst_stall", 32'h0);
        push_expect("rst_sb_err", 32'h0);
        #1;
        check_output(bus.v1);
        check_output(bus.v2);
        check_output(32'(bus.stall));
        check_output(32'(bus.sb_err));

        // Register 0: no bypass, write ignored, no counter fault
        bus.wb_en   = 1'b1;
        bus.wb_rd   = 5'd0;
        bus.wb_data = 32'hDEADBEEF;
        bus.r1      = 5'd0;
        push_expect("r0_bypass_v1", 32'h0);
        #1;
        check_output(bus.v1);
        tick;
        bus.wb_en = 1'b0;
        push_expect("r0_read_v1", 32'h0);
        push_expect("r0_wb_sb_err", 32'h0);
        #1;
        check_output(bus.v1);
        check_output(32'(bus.sb_err));

        // Issue rd=8, then consume r1=8 -> stall
        bus.issue_en = 1'b1;
        bus.issue_rd = 5'd8;
        tick;
        bus.issue_en = 1'b0;
        bus.use1     = 1'b1;
        bus.r1       = 5'd8;
        push_expect("raw_stall", 32'h1);
        #1;
        check_output(32'(bus.stall));

        // Issue rd=10 while stalled is suppressed
        bus.issue_en = 1'b1;
        bus.issue_rd = 5'd10;
        push_expect("suppr_stall", 32'h1);
        #1;
        check_output(32'(bus.stall));
        tick;
        bus.issue_en = 1'b0;
        bus.r1       = 5'd10;
        push_expect("suppr_cnt10_stall", 32'h0);
        #1;
        check_output(32'(bus.stall));

        // Writeback 8 bypassed in the same cycle, then read from the array
        bus.r1      = 5'd8;
        bus.wb_en   = 1'b1;
        bus.wb_rd   = 5'd8;
        bus.wb_data = 32'h0000_1234;
        push_expect("byp_stall", 32'h0);
        push_expect("byp_v1", 32'h0000_1234);
        #1;
        check_output(32'(bus.stall));
        check_output(bus.v1);
        tick;
        bus.wb_en = 1'b0;
        push_expect("arr_v1", 32'h0000_1234);
        push_expect("arr_stall", 32'h0);
        #1;
        check_output(bus.v1);
        check_output(32'(bus.stall));
        bus.use1 = 1'b0;

        // Two writers to 9: first retirement cannot satisfy the read
        bus.issue_en = 1'b1;
        bus.issue_rd = 5'd9;
        tick;
        tick;
        bus.issue_en = 1'b0;
        bus.use2     = 1'b1;
        bus.r2       = 5'd9;
        bus.wb_en    = 1'b1;
        bus.wb_rd    = 5'd9;
        bus.wb_data  = 32'd7;
        push_expect("two_wr_stall", 32'h1);
        #1;
        check_output(32'(bus.stall));
        tick;
        bus.wb_data = 32'd8;
        push_expect("last_wr_stall", 32'h0);
        push_expect("last_wr_v2", 32'd8);
        #1;
        check_output(32'(bus.stall));
        check_output(bus.v2);
        tick;
        bus.wb_en = 1'b0;
        push_expect("after_wr_v2", 32'd8);
        push_expect("after_wr_stall", 32'h0);
        #1;
        check_output(bus.v2);
        check_output(32'(bus.stall));
        bus.use2 = 1'b0;

        // Coincident issue and writeback to 12 keeps cnt at 1
        bus.issue_en = 1'b1;
        bus.issue_rd = 5'd12;
        tick;
        bus.wb_en   = 1'b1;
        bus.wb_rd   = 5'd12;
        bus.wb_data = 32'd5;
        tick;
        bus.issue_en = 1'b0;
        bus.wb_en    = 1'b0;
        bus.use1     = 1'b1;
        bus.r1       = 5'd12;
        push_expect("cnt12_one_stall", 32'h1);
        #1;
        check_output(32'(bus.stall));
        bus.wb_en   = 1'b1;
        bus.wb_data = 32'd6;
        push_expect("cnt12_byp_stall", 32'h0);
        push_expect("cnt12_byp_v1", 32'd6);
        #1;
        check_output(32'(bus.stall));
        check_output(bus.v1);
        tick;
        bus.wb_en = 1'b0;
        push_expect("cnt12_zero_stall", 32'h0);
        push_expect("cnt12_sb_err", 32'h0);
        #1;
        check_output(32'(bus.stall));
        check_output(32'(bus.sb_err));
        bus.use1 = 1'b0;

        // Four issues to 13: saturate at 3 and raise sb_err
        bus.issue_en = 1'b1;
        bus.issue_rd = 5'd13;
        tick;
        tick;
        tick;
        push_expect("pre_ovf_sb_err", 32'h0);
        #1;
        check_output(32'(bus.sb_err));
        tick;
        bus.issue_en = 1'b0;
        push_expect("ovf_sb_err", 32'h1);
        #1;
        check_output(32'(bus.sb_err));
        bus.use1    = 1'b1;
        bus.r1      = 5'd13;
        bus.wb_en   = 1'b1;
        bus.wb_rd   = 5'd13;
        bus.wb_data = 32'd1;
        push_expect("sat3_stall", 32'h1);
        #1;
        check_output(32'(bus.stall));
        tick;
        tick;
        push_expect("sat_last_stall", 32'h0);
        #1;
        check_output(32'(bus.stall));
        tick;
        bus.wb_en = 1'b0;
        push_expect("sat_drained_stall", 32'h0);
        #1;
        check_output(32'(bus.stall));
        bus.use1 = 1'b0;

        // Reset mid-operation discards pending state and data
        bus.issue_en = 1'b1;
        bus.issue_rd = 5'd8;
        tick;
        bus.issue_en = 1'b0;
        reset        = 1'b1;
        tick;
        reset    = 1'b0;
        bus.use1 = 1'b1;
        bus.r1   = 5'd8;
        push_expect("mid_rst_stall", 32'h0);
        push_expect("mid_rst_v1", 32'h0);
        push_expect("mid_rst_sb_err", 32'h0);
        #1;
        check_output(32'(bus.stall));
        check_output(bus.v1);
        check_output(32'(bus.sb_err));
        bus.use1 = 1'b0;

        // Underflow: writeback to idle 14 still writes and flags sb_err
        bus.wb_en   = 1'b1;
        bus.wb_rd   = 5'd14;
        bus.wb_data = 32'h0000_00AB;
        tick;
        bus.wb_en = 1'b0;
        bus.r1    = 5'd14;
        push_expect("unf_v1", 32'h0000_00AB);
        push_expect("unf_sb_err", 32'h1);
        #1;
        check_output(bus.v1);
        check_output(32'(bus.sb_err));

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("[TB] FAIL leftover_expect observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Responder side of the decode-stage register-read interface: returns v1/v2 for r1/r2 and accepts the writeback write.
- Holds the 32x32 MIPS register file plus a per-register pending-write scoreboard.
- Decode allocates a destination at issue; writeback retires it.
- Produces a stall when a source register has an in-flight writer that cannot be bypassed this cycle.

Parameters:
- NUM_REGS, 32, architectural register count; index width is clog2(NUM_REGS).
- PEND_W, 2, width of each pending-writer counter; max in-flight writers per register is 2^PEND_W-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- r1, r2  in  5  source indices from decode (rs, rt).
- use1, use2  in  1  decode actually consumes r1 / r2 this cycle.
- v1, v2  out  32  read data; combinational, with writeback bypass.
- issue_en  in  1  decode issues an instruction with a destination.
- issue_rd  in  5  destination register of the issuing instruction (0 = no destination).
- wb_en  in  1  writeback write valid.
- wb_rd  in  5  writeback destination.
- wb_data  in  32  writeback value.
- stall  out  1  decode must hold; issue is suppressed internally.
- sb_err  out  1  sticky scoreboard error (overflow or underflow).

Behaviour:
- Reset (synchronous, active-high): all registers = 0, all counters = 0, sb_err = 0. Reset mid-operation discards all pending state; in-flight writebacks after reset are treated as underflow (data written, sb_err set).
- Register 0:
  - Reads always return 0.
  - Writes are ignored.
  - Never pending.
  - issue_rd=0 or wb_rd=0 does not touch any counter.
- Read (0 latency, combinational): v1 = (wb_en && wb_rd==r1 && r1!=0) ? wb_data : rf[r1]. v2 is the same with r2.
- Write: on posedge, if wb_en && wb_rd!=0, then rf[wb_rd] <= wb_data.
- Bypass-aware busy:
  - busyN = cnt[rN]!=0 && !(cnt[rN]==1 && wb_en && wb_rd==rN).
  - A single pending writer retiring this cycle is satisfied by the bypass.
- stall = (use1 && busy1) || (use2 && busy2). Combinational.
- Effective issue: iss = issue_en && !stall && issue_rd!=0.
- Counter update per register i, each posedge:
  - +1 if iss && issue_rd==i.
  - -1 if wb_en && wb_rd==i.
  - Both: unchanged.
  - Neither: hold.
- Overflow: increment when cnt==max (with no coincident decrement) → cnt stays max (saturates), sb_err <= 1.
- Underflow: decrement when cnt==0 (with no coincident increment) → cnt stays 0, data still written, sb_err <= 1.
- sb_err is cleared only by reset.
- Same-cycle issue of rd=X while a source reads X: stall is computed from the pre-update count. The self-dependency (e.g. addi $t0,$t0,1) only stalls on older writers.

Optional Feature:
- Macro: REGFILE_DBG_PORT_EN.
- With the macro defined: adds a third read port, dbg_addr in 5 / dbg_data out 32. The port is raw (no bypass; dbg_addr=0 returns 0) and does not affect stall. It also adds dbg_pending out PEND_W = cnt[dbg_addr].
- Without the macro: these ports do not exist, and no extra logic is generated.

Decomposition:
- Package mips_pkg:
  - typedef reg_idx_t (logic [4:0]) and word_t (logic [31:0]).
  - Constants REG_ZERO=0, REG_RA=31, NUM_REGS=32.
  - Shared by decode, execute and writeback.
- Sub-module sb_counter: one per register (generate loop over 1..NUM_REGS-1). Inputs inc and dec; outputs cnt, ovf and unf pulses; saturating PEND_W-bit counter. The top level ORs the ovf/unf pulses into sb_err.

Test Plan:
- Reset, then read r1=5/r2=31 → v1=v2=0, stall=0, sb_err=0; wb $0←0xDEADBEEF, then read r1=0 → v1=0.
- Issue rd=8, next cycle use1 with r1=8 → stall=1. wb 8←0x1234 in the same cycle as a read of r1=8 → stall=0, v1=0x1234 (bypass). Following cycle → v1=0x1234 from the array.
- Issue rd=9 twice (cnt=2), then wb 9←7 once with use2 r2=9 → stall=1. Second wb 9←8 → stall=0, v2=8.
- While stall=1 (r1=8 pending), issue_en with issue_rd=10 → cnt[10] stays 0 (issue suppressed).
- Issue and wb to rd=12 in the same cycle with cnt[12]=1 → cnt stays 1. Four issues to rd=13 with PEND_W=2 → cnt=3, sb_err=1. wb to rd=14 with cnt 0 → rf[14] written, sb_err=1.
- Issue rd=8 then assert reset → cnt[8]=0, stall=0 for r1=8, rf[8]=0, sb_err=0.
